mem_access_unit: RTL and testbench

- Sequential successor to the combinational memory stage of the rv32i pipeline. Sits between EX and WB and owns the data-memory bus handshake.
- Parametrised in data width (XLEN 32/64) and response timeout.
- Registers the EX payload, sequences bus transactions through an FSM, stalls upstream while a transaction is outstanding, and flags timeouts and misaligned accesses.
- Emits one registered WB beat per accepted instruction.

---
 rtl/mem_access_unit_if.sv | 18 +
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory bus between mem_access_unit (master) and the memory (slave).
interface mem_access_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] data_mem_addr;
  logic [XLEN-1:0] data_to_mem;
  logic [XLEN-1:0] data_from_mem;
  logic            require_mem_access;
  logic            write;
  logic            data_mem_access_ready_n;
  logic [2:0]      size;
  modport master(
    output data_mem_addr, require_mem_access, write, size, data_to_mem,
    input  data_mem_access_ready_n, data_from_mem
  );
  modport slave(
    input  data_mem_addr, require_mem_access, write, size, data_to_mem,
    output data_mem_access_ready_n, data_from_mem
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: registered MEM stage that runs the data-bus handshake and emits one WB beat per instruction.
// Define MISALIGNED_SPLIT_EN to serve misaligned loads with two aligned full-width reads.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       pc_from_ex,
  input  logic [4:0]        rd_from_ex,
  input  logic [XLEN-1:0]   b,
  input  logic [XLEN-1:0]   c,
  output logic              stall,
  output logic              wb_valid,
  output logic [31:0]       pc_to_wb,
  output logic [4:0]        rd_to_wb,
  output logic [6:0]        opcode_to_wb,
  output logic [XLEN-1:0]   d,
  output logic              access_fault,
  output logic              misaligned,
  mem_access_unit_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT) + 1;
`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE, REQ, REQ2, DONE} state_t;
  logic [XLEN-1:0] first;
  logic            split_r;
`else
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic [LW-1:0]     off;
  logic              req, is_ld, is_st, mem, mis, split, ready;
  logic [2:0]        sz;
  logic [XLEN-1:0]   wdata, sh, ld;
  logic [2*XLEN-1:0] raw;
  assign bus.require_mem_access = req & rst_n;
  always_comb begin
    is_ld = opcode == 7'b0000011;
    is_st = opcode == 7'b0100011;
    mem = is_ld ? funct3 != 3'b111 && (XLEN == 64 || (funct3 != 3'b011 && funct3 != 3'b110))
                : is_st && !funct3[2] && (XLEN == 64 || funct3 != 3'b011);
    sz = funct3[1:0] == 2'b00 ? 3'b010 : funct3[1:0] == 2'b01 ? 3'b001 : funct3[1:0] == 2'b10 ? 3'b000 : 3'b100;
    mis = funct3[1:0] == 2'b01 ? c[0] : funct3[1:0] == 2'b10 ? |c[1:0] : funct3[1:0] == 2'b11 ? |c[2:0] : 1'b0;
    wdata = funct3[1:0] == 2'b00 ? {NB{b[7:0]}} : funct3[1:0] == 2'b01 ? {(NB/2){b[15:0]}}
          : funct3[1:0] == 2'b10 ? {(XLEN/32){b[31:0]}} : b;
    ready = !bus.data_mem_access_ready_n;
`ifdef MISALIGNED_SPLIT_EN
    split = is_ld && mis;
    raw = state == REQ2 ? {bus.data_from_mem, first} : {{XLEN{1'b0}}, bus.data_from_mem};
`else
    split = 1'b0;
    raw = {{XLEN{1'b0}}, bus.data_from_mem};
`endif
    // little-endian lane select; the split case shifts across the concatenated pair
    sh = XLEN'(raw >> {off, 3'b000});
    ld = f3 == 3'b000 ? XLEN'($signed(sh[7:0])) : f3 == 3'b001 ? XLEN'($signed(sh[15:0]))
       : f3 == 3'b010 ? XLEN'($signed(sh[31:0])) : f3 == 3'b100 ? XLEN'(sh[7:0])
       : f3 == 3'b101 ? XLEN'(sh[15:0]) : f3 == 3'b110 ? XLEN'(sh[31:0]) : sh;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      off <= '0;
      req <= 1'b0;
      stall <= 1'b0;
      wb_valid <= 1'b0;
      pc_to_wb <= '0;
      rd_to_wb <= '0;
      opcode_to_wb <= '0;
      d <= '0;
      access_fault <= 1'b0;
      misaligned <= 1'b0;
      bus.data_mem_addr <= '0;
      bus.write <= 1'b0;
      bus.size <= 3'b011;
      bus.data_to_mem <= '0;
`ifdef MISALIGNED_SPLIT_EN
      first <= '0;
      split_r <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      access_fault <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE, DONE:
          if (!in_valid) state <= IDLE;
          else begin
            pc_to_wb <= pc_from_ex;
            rd_to_wb <= rd_from_ex;
            opcode_to_wb <= opcode;
            f3 <= funct3;
            off <= c[LW-1:0];
            cnt <= '0;
`ifdef MISALIGNED_SPLIT_EN
            split_r <= split;
`endif
            if (mem && (!mis || split)) begin
              state <= REQ;
              req <= 1'b1;
              stall <= 1'b1;
              bus.write <= is_st;
              bus.size <= split ? (XLEN == 64 ? 3'b100 : 3'b000) : sz;
              bus.data_mem_addr <= split ? c & ~XLEN'(NB - 1) : c;
              bus.data_to_mem <= is_st ? wdata : '0;
            end else begin
              state <= DONE;
              wb_valid <= 1'b1;
              misaligned <= mem;
              d <= mem ? '0 : c;
            end
          end
        default:
`ifdef MISALIGNED_SPLIT_EN
          if (state == REQ && split_r && ready) begin
            state <= REQ2;
            first <= bus.data_from_mem;
            cnt <= '0;
            bus.data_mem_addr <= bus.data_mem_addr + XLEN'(NB);
          end else
`endif
          if (ready || cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            req <= 1'b0;
            stall <= 1'b0;
            bus.write <= 1'b0;
            bus.size <= 3'b011;
            bus.data_to_mem <= '0;
            wb_valid <= 1'b1;
            access_fault <= !ready;
            d <= (!ready || opcode_to_wb[5]) ? '0 : ld;
          end else cnt <= cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector bench for mem_access_unit at XLEN=32, TIMEOUT=4.
module tb_mem_access_unit;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, OP = 7'b0110011;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] pc_from_ex = 0, b = 0, c = 0;
  logic [4:0] rd_from_ex = 0;
  logic stall, wb_valid, access_fault, misaligned;
  logic [31:0] pc_to_wb, d;
  logic [4:0] rd_to_wb;
  logic [6:0] opcode_to_wb;
  int checks = 0, errors = 0;
  mem_access_unit_if #(.XLEN(32)) bus();
  mem_access_unit #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
    .pc_from_ex(pc_from_ex), .rd_from_ex(rd_from_ex), .b(b), .c(c),
    .stall(stall), .wb_valid(wb_valid), .pc_to_wb(pc_to_wb), .rd_to_wb(rd_to_wb),
    .opcode_to_wb(opcode_to_wb), .d(d), .access_fault(access_fault), .misaligned(misaligned),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [31:0] c, b, rdata; int delay;
    logic bus_on, wr; logic [2:0] sz; logic [31:0] wd, d; int stalls; logic fault, mis;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t t, input int idx);
    int n, nr, g;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    in_valid = 1; opcode = t.op; funct3 = t.f3; c = t.c; b = t.b;
    pc_from_ex = 32'h1000 + 32'(idx * 4); rd_from_ex = 5'(idx);
    @(posedge clk); #1;
    in_valid = 0;
    chk({p, ".req"}, 32'(bus.require_mem_access), 32'(t.bus_on));
    if (t.bus_on) begin
      chk({p, ".write"}, 32'(bus.write), 32'(t.wr));
      chk({p, ".size"}, 32'(bus.size), 32'(t.sz));
      chk({p, ".wdata"}, bus.data_to_mem, t.wd);
      chk({p, ".addr"}, bus.data_mem_addr, t.c);
    end
    n = 0; nr = 0; g = 0;
    while (!wb_valid && g < 20) begin
      n += int'(stall);
      nr += int'(bus.require_mem_access);
      bus.data_mem_access_ready_n = n < t.delay;
      bus.data_from_mem = t.rdata;
      @(posedge clk); #1;
      g++;
    end
    bus.data_mem_access_ready_n = 1;
    chk({p, ".stall_cycles"}, 32'(n), 32'(t.stalls));
    chk({p, ".req_cycles"}, 32'(nr), 32'(t.stalls));
    chk({p, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({p, ".d"}, d, t.d);
    chk({p, ".fault"}, 32'(access_fault), 32'(t.fault));
    chk({p, ".mis"}, 32'(misaligned), 32'(t.mis));
    chk({p, ".pc"}, pc_to_wb, 32'h1000 + 32'(idx * 4));
    chk({p, ".rd"}, 32'(rd_to_wb), 32'(idx));
    chk({p, ".op"}, 32'(opcode_to_wb), 32'(t.op));
    chk({p, ".size_done"}, 32'(bus.size), 32'd3);
    chk({p, ".req_done"}, 32'(bus.require_mem_access), 32'd0);
    chk({p, ".stall_done"}, 32'(stall), 32'd0);
    chk({p, ".wdata_done"}, bus.data_to_mem, 32'd0);
  endtask
  initial begin
    bus.data_mem_access_ready_n = 1;
    bus.data_from_mem = 0;
    //           op  f3      c            b             rdata        dly bus wr sz      wd            d             st flt mis
    tv.push_back('{LD, 3'b000, 32'h2,    32'h0,        32'ha0b1c2d3, 1,  1, 0, 3'b010, 32'h0,        32'hffffffb1, 1, 0, 0});
    tv.push_back('{LD, 3'b101, 32'h0,    32'h0,        32'ha0b1c2d3, 3,  1, 0, 3'b001, 32'h0,        32'h0000c2d3, 3, 0, 0});
    tv.push_back('{LD, 3'b010, 32'h4,    32'h0,        32'ha0b1c2d3, 3,  1, 0, 3'b000, 32'h0,        32'ha0b1c2d3, 3, 0, 0});
    tv.push_back('{ST, 3'b000, 32'h1234, 32'h87654321, 32'h0,        1,  1, 1, 3'b010, 32'h21212121, 32'h0,        1, 0, 0});
    tv.push_back('{ST, 3'b001, 32'h1236, 32'h87654321, 32'h0,        2,  1, 1, 3'b001, 32'h43214321, 32'h0,        2, 0, 0});
    tv.push_back('{LD, 3'b010, 32'h100,  32'h0,        32'h12345678, 99, 1, 0, 3'b000, 32'h0,        32'h0,        4, 1, 0});
    tv.push_back('{LD, 3'b001, 32'h2,    32'h0,        32'h80017fff, 2,  1, 0, 3'b001, 32'h0,        32'hffff8001, 2, 0, 0});
    tv.push_back('{LD, 3'b100, 32'h3,    32'h0,        32'ha0b1c2d3, 1,  1, 0, 3'b010, 32'h0,        32'h000000a0, 1, 0, 0});
    tv.push_back('{ST, 3'b010, 32'h8,    32'hdeadbeef, 32'h0,        4,  1, 1, 3'b000, 32'hdeadbeef, 32'h0,        4, 0, 0});
    tv.push_back('{ST, 3'b010, 32'h1235, 32'hdeadbeef, 32'h0,        0,  0, 0, 3'b011, 32'h0,        32'h0,        0, 0, 1});
    tv.push_back('{LD, 3'b011, 32'h77,   32'h0,        32'h0,        0,  0, 0, 3'b011, 32'h0,        32'h77,       0, 0, 0});
`ifndef MISALIGNED_SPLIT_EN
    tv.push_back('{LD, 3'b010, 32'h1235, 32'h0,        32'h0,        0,  0, 0, 3'b011, 32'h0,        32'h0,        0, 0, 1});
    tv.push_back('{LD, 3'b001, 32'h1,    32'h0,        32'h0,        0,  0, 0, 3'b011, 32'h0,        32'h0,        0, 0, 1});
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wb_valid", 32'(wb_valid), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.req", 32'(bus.require_mem_access), 0);
    chk("rst.size", 32'(bus.size), 32'd3);
    chk("rst.d", d, 0);
    chk("rst.addr", bus.data_mem_addr, 0);
    chk("rst.write", 32'(bus.write), 0);
    chk("rst.fault_mis", {30'd0, access_fault, misaligned}, 0);
    @(negedge clk);
    rst_n = 1;
    foreach (tv[i]) run(tv[i], i);
    @(posedge clk); #1;
    chk("beat_one_cycle", 32'(wb_valid), 0);
`ifdef MISALIGNED_SPLIT_EN
    @(negedge clk);
    in_valid = 1; opcode = LD; funct3 = 3'b010; c = 32'h1235;
    @(posedge clk); #1;
    in_valid = 0;
    chk("split.addr1", bus.data_mem_addr, 32'h1234);
    chk("split.req1", 32'(bus.require_mem_access), 1);
    chk("split.size", 32'(bus.size), 0);
    bus.data_mem_access_ready_n = 0; bus.data_from_mem = 32'ha0b1c2d3;
    @(posedge clk); #1;
    chk("split.addr2", bus.data_mem_addr, 32'h1238);
    chk("split.req2", 32'(bus.require_mem_access), 1);
    chk("split.stall2", 32'(stall), 1);
    chk("split.no_beat", 32'(wb_valid), 0);
    bus.data_from_mem = 32'h11223344;
    @(posedge clk); #1;
    bus.data_mem_access_ready_n = 1;
    chk("split.wb_valid", 32'(wb_valid), 1);
    chk("split.d", d, 32'h44a0b1c2);
    chk("split.mis", 32'(misaligned), 0);
`endif
    // abort a pending load with reset, then show the FSM is idle and ignores ready
    @(negedge clk);
    in_valid = 1; opcode = LD; funct3 = 3'b010; c = 32'h40;
    @(posedge clk); #1;
    in_valid = 0;
    chk("abort.req_before", 32'(bus.require_mem_access), 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort.req_in_rst", 32'(bus.require_mem_access), 0);
    @(posedge clk); #1;
    chk("abort.wb_valid", 32'(wb_valid), 0);
    chk("abort.stall", 32'(stall), 0);
    chk("abort.size", 32'(bus.size), 32'd3);
    @(negedge clk);
    rst_n = 1;
    bus.data_mem_access_ready_n = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort.no_beat", 32'(wb_valid), 0);
      chk("abort.idle_req", 32'(bus.require_mem_access), 0);
    end
    bus.data_mem_access_ready_n = 1;
    run('{OP, 3'b000, 32'h55, 32'h0, 32'h0, 0, 0, 0, 3'b011, 32'h0, 32'h55, 0, 0, 0}, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
